// File: rtl/cpu_defs.sv
// Shared CPU definitions: divider state encoding and default datapath width.
package cpu_defs;

    localparam int DIV_WIDTH = 32;

    typedef logic [1:0] div_state_t;

    localparam div_state_t DIV_IDLE = 2'd0;
    localparam div_state_t DIV_CALC = 2'd1;
    localparam div_state_t DIV_SIGN = 2'd2;
    localparam div_state_t DIV_DONE = 2'd3;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on magnitudes: shift {rem,quo} left, trial-subtract divisor.
module div_step
    import cpu_defs::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH:0]   divisor_i,
    output logic [WIDTH:0]   rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH+1:0] shifted;
    logic             fits;

    always_comb begin
        shifted = {rem_i, quo_i[WIDTH-1]};
        fits    = shifted >= {1'b0, divisor_i};
        quo_o   = {quo_i[WIDTH-2:0], fits};
        // The difference is below the divisor whenever it is kept, so its top bit is always zero.
        rem_o   = fits ? (WIDTH+1)'(shifted - {1'b0, divisor_i}) : shifted[WIDTH:0];
    end

endmodule

// File: rtl/div_unit.sv
// Multicycle signed divider for MIPS DIV: hi_out = remainder, lo_out = quotient.
module div_unit
    import cpu_defs::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH:0]   divisor_q, divisor_d;
    logic             sign_q_q, sign_q_d;
    logic             sign_r_q, sign_r_d;
    logic             div_zero_q, div_zero_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH:0]   rem_step;
    logic [WIDTH-1:0] quo_step;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (divisor_q),
        .rem_o     (rem_step),
        .quo_o     (quo_step)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        divisor_d  = divisor_q;
        sign_q_d   = sign_q_q;
        sign_r_d   = sign_r_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;

        case (state_q)
            DIV_IDLE: begin
                if (start) begin
                    if (b_in == '0) begin
                        div_zero_d = 1'b1;
                        state_d    = DIV_DONE;
                    end else begin
                        // Unsigned magnitude of -2^(WIDTH-1) is exact in WIDTH bits.
                        quo_d     = a_in[WIDTH-1] ? (~a_in + 1'b1) : a_in;
                        divisor_d = {1'b0, (b_in[WIDTH-1] ? (~b_in + 1'b1) : b_in)};
                        sign_q_d  = a_in[WIDTH-1] ^ b_in[WIDTH-1];
                        sign_r_d  = a_in[WIDTH-1];
                        rem_d     = '0;
                        cnt_d     = '0;
                        state_d   = DIV_CALC;
                    end
                end
            end
            DIV_CALC: begin
                rem_d = rem_step;
                quo_d = quo_step;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = DIV_SIGN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DIV_SIGN: begin
                lo_d    = sign_q_q ? (~quo_q + 1'b1) : quo_q;
                hi_d    = WIDTH'(sign_r_q ? (~rem_q + 1'b1) : rem_q);
                state_d = DIV_DONE;
            end
            default: begin
                div_zero_d = 1'b0;
                state_d    = DIV_IDLE;
            end
        endcase
    end

    // NOTE: state uses non-blocking assignments with an async active-low reset so an
    // abort takes effect immediately and every flop updates from the same snapshot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= DIV_IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            divisor_q  <= '0;
            sign_q_q   <= 1'b0;
            sign_r_q   <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            divisor_q  <= divisor_d;
            sign_q_q   <= sign_q_d;
            sign_r_q   <= sign_r_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign busy     = (state_q == DIV_CALC) || (state_q == DIV_SIGN);
    assign done     = (state_q == DIV_DONE);
    assign div_zero = div_zero_q;
    assign hi_out   = hi_q;
    assign lo_out   = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: vector table plus zero-divisor, restart and reset-abort sequences.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] a_in, b_in;
    logic        busy, done, div_zero;
    logic [31:0] hi_out, lo_out;

    int n_checks = 0;
    int n_fail   = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi_out   (hi_out),
        .lo_out   (lo_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Start edge is the posedge between the two negedges; returns at the negedge after it.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a_in  = $urandom;
        b_in  = $urandom;
    endtask

    // lat = number of posedges after the start edge at which done is seen (-1 on timeout).
    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = -1;
        busy_cnt = 0;
        for (int n = 0; n < 100; n++) begin
            if (done) begin
                lat = n;
                break;
            end
            if (busy) busy_cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[10];
        int   lat, bcnt, extra;

        vecs[0] = '{a: 32'd100,        b: 32'd7,          lo: 32'd14,         hi: 32'd2};
        vecs[1] = '{a: -32'sd100,      b: 32'd7,          lo: 32'hFFFFFFF2,   hi: 32'hFFFFFFFE};
        vecs[2] = '{a: 32'd100,        b: -32'sd7,        lo: 32'hFFFFFFF2,   hi: 32'd2};
        vecs[3] = '{a: -32'sd100,      b: -32'sd7,        lo: 32'd14,         hi: 32'hFFFFFFFE};
        vecs[4] = '{a: 32'h80000000,   b: 32'hFFFFFFFF,   lo: 32'h80000000,   hi: 32'd0};
        vecs[5] = '{a: 32'h80000000,   b: 32'd1,          lo: 32'h80000000,   hi: 32'd0};
        vecs[6] = '{a: -32'sd7,        b: 32'd2,          lo: 32'hFFFFFFFD,   hi: 32'hFFFFFFFF};
        vecs[7] = '{a: 32'h7FFFFFFF,   b: 32'h80000000,   lo: 32'd0,          hi: 32'h7FFFFFFF};
        vecs[8] = '{a: 32'd7,          b: 32'd100,        lo: 32'd0,          hi: 32'd7};
        vecs[9] = '{a: 32'hFFFFFFFF,   b: 32'h7FFFFFFF,   lo: 32'd0,          hi: 32'hFFFFFFFF};

        reset = 1'b0;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (2) @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset div_zero", {31'd0, div_zero}, 32'd0);
        check("reset hi", hi_out, 32'd0);
        check("reset lo", lo_out, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            start_op(vecs[i].a, vecs[i].b);
            wait_done(lat, bcnt);
            check($sformatf("vec%0d latency", i), lat, 32'd33);
            check($sformatf("vec%0d busy cycles", i), bcnt, 32'd33);
            check($sformatf("vec%0d lo", i), lo_out, vecs[i].lo);
            check($sformatf("vec%0d hi", i), hi_out, vecs[i].hi);
            check($sformatf("vec%0d div_zero", i), {31'd0, div_zero}, 32'd0);
            @(negedge clk);
            check($sformatf("vec%0d done pulse width", i), {31'd0, done}, 32'd0);
        end

        // Zero divisor: results from the prior divide must survive.
        start_op(32'h451, 32'h20);
        wait_done(lat, bcnt);
        check("pre-zero lo", lo_out, 32'h22);
        check("pre-zero hi", hi_out, 32'h11);
        start_op(32'd5, 32'd0);
        wait_done(lat, bcnt);
        check("zero latency", lat, 32'd0);
        check("zero busy cycles", bcnt, 32'd0);
        check("zero div_zero", {31'd0, div_zero}, 32'd1);
        check("zero hi kept", hi_out, 32'h11);
        check("zero lo kept", lo_out, 32'h22);
        @(negedge clk);
        check("zero done cleared", {31'd0, done}, 32'd0);
        check("zero div_zero cleared", {31'd0, div_zero}, 32'd0);
        check("zero busy idle", {31'd0, busy}, 32'd0);

        // start pulsed mid-divide is ignored.
        start_op(32'd100, 32'd7);
        lat = -1;
        for (int n = 0; n < 100; n++) begin
            if (done) begin
                lat = n;
                break;
            end
            if (n == 10) begin
                start = 1'b1;
                a_in  = 32'd9;
                b_in  = 32'd0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("restart latency", lat, 32'd33);
        check("restart lo", lo_out, 32'd14);
        check("restart hi", hi_out, 32'd2);
        check("restart div_zero", {31'd0, div_zero}, 32'd0);
        extra = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done) extra++;
        end
        check("restart single done", extra, 32'd0);

        // Reset mid-operation aborts immediately.
        start_op(32'd100, 32'd7);
        repeat (15) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        check("abort hi", hi_out, 32'd0);
        check("abort lo", lo_out, 32'd0);
        extra = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done) extra++;
        end
        check("abort no done", extra, 32'd0);
        reset = 1'b1;
        start_op(32'd9, 32'd3);
        wait_done(lat, bcnt);
        check("post-reset latency", lat, 32'd33);
        check("post-reset lo", lo_out, 32'd3);
        check("post-reset hi", hi_out, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
